prom_sequencer: RTL and testbench
=================================

// Module: prom_sequencer
// PURPOSE
//   Plays LED patterns stored in the on-chip prom (128 x 36, one-cycle synchronous read).
//   Steps a ROM address through a programmable range [first_addr..last_addr], one entry per frame.
//   Sets the frame period with a prescaler and registers each word onto pattern for the bank outputs.
//   Sole master of the prom port: drives AddressA and ClkEn0, reads DataOutA.
// PARAMETERS
//   ADDR_W  7   ROM address width (depth 2**ADDR_W)
//   DATA_W  36  ROM word width
//   DIV_W   24  frame-hold counter width
// PORTS
//   clk          in   1       system clock; also drives prom Clk0
//   rst_n        in   1       asynchronous, active-low reset
//   start        in   1       begin playback from first_addr (level-sampled each cycle)
//   stop         in   1       abort to IDLE; has priority over start and step
//   step         in   1       IDLE only: fetch one word at cur_addr, then advance
//   loop_en      in   1       1: wrap last_addr->first_addr; 0: finish after last_addr
//   first_addr   in   ADDR_W  range start; shadowed when start is accepted
//   last_addr    in   ADDR_W  range end; shadowed when start is accepted
//   div          in   DIV_W   HOLD cycles per frame (0 treated as 1); shadowed on start
//   rom_clk_en   out  1       to prom ClkEn0
//   rom_addr     out  ADDR_W  to prom AddressA
//   rom_data     in   DATA_W  from prom DataOutA
//   pattern      out  DATA_W  last captured ROM word
//   pattern_vld  out  1       1-cycle pulse when pattern updates
//   busy         out  1       high whenever state != IDLE
//   done         out  1       1-cycle pulse at end of a non-looping run
// BEHAVIOUR
//   - Reset (async): all outputs 0; state IDLE; cur_addr 0.
//     Shadows reset to first=0, last=2**ADDR_W-1, div=0.
//   - States: IDLE, FETCH, CAPTURE, HOLD.
//   - IDLE:
//     - start: latch shadows; cur_addr<=first_addr; go FETCH.
//     - step (no start): go FETCH with stepping flag set.
//   - FETCH: rom_addr=cur_addr, rom_clk_en=1; next CAPTURE. rom_clk_en is 0 in every other state.
//   - CAPTURE: pattern<=rom_data and pattern_vld<=1 at the closing edge.
//     - Stepping: advance cur_addr; go IDLE.
//     - Otherwise: load hold counter with max(div,1); go HOLD.
//   - HOLD: decrement the counter; at 1, advance:
//     - cur_addr!=last: cur_addr+1 mod 2**ADDR_W; go FETCH.
//     - cur_addr==last, loop_en=1: cur_addr<=first; go FETCH.
//     - cur_addr==last, loop_en=0: cur_addr<=first; go IDLE; done=1 the following cycle.
//   - Latency and period:
//     - First pattern_vld is 3 cycles after the cycle that samples start.
//     - Frame period is max(div,1)+2 cycles.
//   - Address range: first>last is legal and wraps through 0.
//     first==last plays one word repeatedly (loop) or once.
//   - Step advance uses the same rule: cur_addr==last -> first; else +1 mod 2**ADDR_W.
//   - stop, any state: IDLE at the next edge. An in-flight fetch is discarded (no pattern_vld), pattern holds.
//     No done pulse. cur_addr is kept.
//   - start while busy (no stop): restart. Re-latch shadows; go FETCH at first_addr.
//   - start and step together in IDLE: start wins.
//   - step while busy: ignored.
//   - loop_en is live, sampled at the final HOLD cycle.
//   - rst_n asserted mid-frame: immediate return to reset values. pattern clears to 0.
// STRUCTURE
//   - prom_seq_pkg: state enum typedef prom_seq_state_t; default ADDR_W/DATA_W/DIV_W constants.
//   - Sub-module prom_seq_prescaler: loadable DIV_W down-counter with a terminal flag (tc when count==1).
//   - Top: FSM, address/shadow registers, pattern register.
// TESTING  (ROM model: 1-cycle registered read honouring ClkEn0, data = addr zero-extended)
//   1. Drop rst_n mid-HOLD -> all outputs 0 the same cycle; busy=0 after release; step then gives pattern=0.
//   2. first=2 last=4 div=3 loop_en=0 start -> pattern 2,3,4, pattern_vld period 5, first 3 cycles after start.
//      done pulse 1 cycle after the last HOLD; busy=0.
//   3. first=126 last=1 div=1 loop_en=1 -> 126,127,0,1,126,... with period 3.
//   4. stop during FETCH -> no pattern_vld; pattern keeps the previous value; busy=0 the next cycle; no done.
//   5. After reset, 3 isolated step pulses -> pattern 0,1,2; busy high exactly 2 cycles per step.
//      step held during playback has no effect.
//   6. div=0 -> period 3. start+stop in the same cycle -> stays IDLE.
//      start mid-run (first=10) -> next pattern 10.

Source files
------------

// File: rtl/prom_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prom_seq_pkg
// Brief   : Shared types and default widths for the prom pattern sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package prom_seq_pkg;

  // Default geometry of the on-chip prom and the frame-hold counter
  localparam int c_def_addr_w = 7;
  localparam int c_def_data_w = 36;
  localparam int c_def_div_w  = 24;

  // Sequencer states: fetch drives the prom, capture registers its output,
  // hold waits out the frame before the next fetch.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } prom_seq_state_t;

endpackage : prom_seq_pkg
`default_nettype wire

// File: rtl/prom_seq_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : prom_seq_prescaler
// Brief   : Loadable down-counter timing the HOLD phase of each frame.
//           tc is high while the count equals 1 (the last hold cycle).
// Revision: 1.0 - initial release
// ============================================================================
module prom_seq_prescaler
  import prom_seq_pkg::*;
#(
  parameter int DIV_W = c_def_div_w
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_count;

  // Load has priority; otherwise count down while the sequencer holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec) begin
      r_count <= r_count - c_one;
    end
  end

  assign tc = (r_count == c_one);

endmodule : prom_seq_prescaler
`default_nettype wire

// File: rtl/prom_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : prom_sequencer
// Brief   : Steps the prom address through [first_addr..last_addr], one word
//           per frame, and registers each word onto pattern. Sole master of
//           the prom read port (AddressA / ClkEn0 / DataOutA).
// Revision: 1.0 - initial release
// ============================================================================
module prom_sequencer
  import prom_seq_pkg::*;
#(
  parameter int ADDR_W = c_def_addr_w,
  parameter int DATA_W = c_def_data_w,
  parameter int DIV_W  = c_def_div_w
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DIV_W-1:0]  div,
  output logic              rom_clk_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] pattern,
  output logic              pattern_vld,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]  c_div_one  = {{(DIV_W-1){1'b0}}, 1'b1};

  prom_seq_state_t   r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_first;
  logic [ADDR_W-1:0] r_last;
  logic [DIV_W-1:0]  r_div;
  logic              r_stepping;
  logic              r_rom_clk_en;
  logic [DATA_W-1:0] r_pattern;
  logic              r_pattern_vld;
  logic              r_busy;
  logic              r_done;

  logic              w_at_last;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DIV_W-1:0]  w_hold_len;
  logic              w_tc;

  // Advance rule shared by playback and single-step: last wraps to first,
  // otherwise +1 modulo the prom depth (so first > last wraps through 0).
  assign w_at_last   = (r_cur_addr == r_last);
  assign w_next_addr = w_at_last ? r_first : (r_cur_addr + c_addr_one);
  // A zero divider still holds for one cycle
  assign w_hold_len  = (r_div == '0) ? c_div_one : r_div;

  prom_seq_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (r_state == ST_CAPTURE && !r_stepping),
    .load_val (w_hold_len),
    .dec      (r_state == ST_HOLD),
    .tc       (w_tc)
  );

  // Sequencer FSM with registered prom enable, pattern, and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_first       <= '0;
      r_last        <= '1;
      r_div         <= '0;
      r_stepping    <= 1'b0;
      r_rom_clk_en  <= 1'b0;
      r_pattern     <= '0;
      r_pattern_vld <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_pattern_vld <= 1'b0;
      r_done        <= 1'b0;
      r_rom_clk_en  <= 1'b0;
      if (stop) begin
        // Abort: any in-flight fetch is dropped, pattern and address kept
        r_state    <= ST_IDLE;
        r_stepping <= 1'b0;
        r_busy     <= 1'b0;
      end else if (start) begin
        // Start (or restart while busy) latches a fresh range and divider
        r_first      <= first_addr;
        r_last       <= last_addr;
        r_div        <= div;
        r_cur_addr   <= first_addr;
        r_stepping   <= 1'b0;
        r_state      <= ST_FETCH;
        r_rom_clk_en <= 1'b1;
        r_busy       <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (step) begin
              r_stepping   <= 1'b1;
              r_state      <= ST_FETCH;
              r_rom_clk_en <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
          ST_FETCH: begin
            r_state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            r_pattern     <= rom_data;
            r_pattern_vld <= 1'b1;
            if (r_stepping) begin
              r_cur_addr <= w_next_addr;
              r_stepping <= 1'b0;
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (w_tc) begin
              r_cur_addr <= w_next_addr;
              if (w_at_last && !loop_en) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state      <= ST_FETCH;
                r_rom_clk_en <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom_clk_en  = r_rom_clk_en;
  assign rom_addr    = r_cur_addr;
  assign pattern     = r_pattern;
  assign pattern_vld = r_pattern_vld;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule : prom_sequencer
`default_nettype wire

// File: tb/tb_prom_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_prom_sequencer
// Brief   : Self-checking bench for prom_sequencer with a 1-cycle prom model
//           (data = address zero-extended) and an expected-pattern queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prom_sequencer;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 36;
  localparam int DIV_W  = 24;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              step;
  logic              loop_en;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [DIV_W-1:0]  div;
  logic              rom_clk_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] pattern;
  logic              pattern_vld;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [DATA_W-1:0] exp_q[$];

  prom_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .loop_en     (loop_en),
    .first_addr  (first_addr),
    .last_addr   (last_addr),
    .div         (div),
    .rom_clk_en  (rom_clk_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pattern     (pattern),
    .pattern_vld (pattern_vld),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // prom model: registered read gated by ClkEn0, contents = address
  initial rom_data = '0;
  always @(posedge clk) if (rom_clk_en) rom_data <= DATA_W'(rom_addr);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a pattern_vld, sampled on the falling edge
  task automatic wait_vld(input int budget, output bit got, output int at);
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pattern_vld) begin
        got = 1'b1;
        at  = cyc;
        return;
      end
    end
  endtask

  // Pulse start for one sampled edge; k is the cycle that samples it
  task automatic kick(input int f, input int l, input int d, input bit lp, output int k);
    first_addr = ADDR_W'(f);
    last_addr  = ADDR_W'(l);
    div        = DIV_W'(d);
    loop_en    = lp;
    start      = 1'b1;
    k          = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic do_stop();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_q.delete();
  endtask

  // Collect n frames: pattern from the queue, first latency 3, fixed period
  task automatic run_frames(input string name, input int n, input int k, input int period);
    bit got;
    int at;
    int prev;
    logic [DATA_W-1:0] exp;
    prev = -1;
    for (int i = 0; i < n; i++) begin
      wait_vld(40, got, at);
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL %s_vld%0d: no pattern_vld within budget", name, i);
        return;
      end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      if (pattern !== exp) begin
        failures++;
        $display("FAIL %s_pat%0d: got %0d expected %0d", name, i, pattern, exp);
      end
      checks++;
      if (i == 0 && at != k + 3) begin
        failures++;
        $display("FAIL %s_latency: got %0d cycles expected 3", name, at - k);
      end else if (i != 0 && at - prev != period) begin
        failures++;
        $display("FAIL %s_period%0d: got %0d expected %0d", name, i, at - prev, period);
      end
      prev = at;
    end
  endtask

  task automatic test_reset();
    int k;
    bit got;
    int at;
    logic [46:0] outs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {rom_clk_en, rom_addr, pattern, pattern_vld, busy, done};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    tick();
    kick(2, 4, 8, 1'b1, k);
    exp_q.push_back(36'd2);
    run_frames("rst_pre", 1, k, 10);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    outs = {rom_clk_en, rom_addr, pattern, pattern_vld, busy, done};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_midhold: got %h expected 0", outs);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tick();
    exp_q.push_back(36'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_vld(10, got, at);
    checks++;
    if (!got || pattern !== exp_q.pop_front()) begin
      failures++;
      $display("FAIL reset_step: got vld=%b pattern=%0d expected pattern 0", got, pattern);
    end
  endtask

  task automatic test_single_run();
    int k;
    int done_at;
    bit done_busy;
    tick();
    kick(2, 4, 3, 1'b0, k);
    exp_q.push_back(36'd2);
    exp_q.push_back(36'd3);
    exp_q.push_back(36'd4);
    run_frames("run", 3, k, 5);
    // last vld cycle is the first of 3 HOLD cycles; done follows the last
    k = cyc;
    done_at = -1;
    done_busy = 1'b1;
    for (int i = 0; i < 10 && done_at < 0; i++) begin
      @(negedge clk);
      if (done) begin
        done_at = cyc;
        done_busy = busy;
      end
    end
    checks++;
    if (done_at != k + 3) begin
      failures++;
      $display("FAIL run_done: got done %0d cycles after last vld, expected 3", done_at - k);
    end
    checks++;
    if (done_busy !== 1'b0) begin
      failures++;
      $display("FAIL run_done_busy: got %b expected 0", done_busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL run_done_pulse: got %b expected 0 on following cycle", done);
    end
  endtask

  task automatic test_wrap();
    int k;
    int seq[6] = '{126, 127, 0, 1, 126, 127};
    tick();
    kick(126, 1, 1, 1'b1, k);
    foreach (seq[i]) exp_q.push_back(DATA_W'(seq[i]));
    run_frames("wrap", 6, k, 3);
    do_stop();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_stop_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_stop_fetch();
    int k;
    bit saw_vld;
    bit saw_done;
    tick();
    kick(20, 30, 4, 1'b1, k);
    exp_q.push_back(36'd20);
    run_frames("stop", 1, k, 6);
    repeat (4) tick();
    checks++;
    if (rom_clk_en !== 1'b1 || rom_addr !== 7'd21) begin
      failures++;
      $display("FAIL stop_in_fetch: got en=%b addr=%0d expected en=1 addr=21", rom_clk_en, rom_addr);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_busy: got %b expected 0", busy);
    end
    saw_vld = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_vld  |= pattern_vld;
      saw_done |= done;
      @(negedge clk);
    end
    checks++;
    if (saw_vld || saw_done) begin
      failures++;
      $display("FAIL stop_quiet: got vld=%b done=%b expected both 0", saw_vld, saw_done);
    end
    checks++;
    if (pattern !== 36'd20) begin
      failures++;
      $display("FAIL stop_pattern: got %0d expected 20", pattern);
    end
    exp_q.delete();
  endtask

  task automatic test_step();
    int k;
    int busy_cnt;
    int vld_cnt;
    logic [DATA_W-1:0] exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int s = 0; s < 3; s++) begin
      tick();
      exp_q.push_back(DATA_W'(s));
      step = 1'b1;
      busy_cnt = 0;
      vld_cnt = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        busy_cnt += int'(busy);
        if (pattern_vld) begin
          vld_cnt++;
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          checks++;
          if (pattern !== exp) begin
            failures++;
            $display("FAIL step_pat%0d: got %0d expected %0d", s, pattern, exp);
          end
        end
        if (c == 0) begin
          @(posedge clk);
          #1 step = 1'b0;
        end
      end
      checks++;
      if (busy_cnt != 2 || vld_cnt != 1) begin
        failures++;
        $display("FAIL step_shape%0d: got busy=%0d vld=%0d expected busy=2 vld=1", s, busy_cnt, vld_cnt);
      end
    end
    // step held (and coincident with start) during playback must not interfere
    tick();
    step = 1'b1;
    kick(40, 41, 2, 1'b1, k);
    exp_q.push_back(36'd40);
    exp_q.push_back(36'd41);
    exp_q.push_back(36'd40);
    run_frames("step_held", 3, k, 4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL step_held_busy: got %b expected 1", busy);
    end
    step = 1'b0;
    do_stop();
  endtask

  task automatic test_div0_restart();
    int k;
    bit saw_busy;
    bit saw_vld;
    tick();
    kick(50, 52, 0, 1'b1, k);
    exp_q.push_back(36'd50);
    exp_q.push_back(36'd51);
    exp_q.push_back(36'd52);
    exp_q.push_back(36'd50);
    run_frames("div0", 4, k, 3);
    do_stop();
    tick();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    saw_busy = 1'b0;
    saw_vld  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_busy |= busy;
      saw_vld  |= pattern_vld;
    end
    checks++;
    if (saw_busy || saw_vld) begin
      failures++;
      $display("FAIL start_stop: got busy=%b vld=%b expected both 0", saw_busy, saw_vld);
    end
    tick();
    kick(60, 70, 6, 1'b1, k);
    exp_q.push_back(36'd60);
    run_frames("restart_a", 1, k, 8);
    tick();
    tick();
    kick(10, 12, 1, 1'b1, k);
    exp_q.push_back(36'd10);
    exp_q.push_back(36'd11);
    run_frames("restart_b", 2, k, 3);
    do_stop();
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    step       = 1'b0;
    loop_en    = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    div        = '0;
    test_reset();
    test_single_run();
    test_wrap();
    test_stop_fetch();
    test_step();
    test_div0_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prom_sequencer
`default_nettype wire
